// File: rtl/hsl_convert_sched_if.sv
// Requester, result and converter signals of hsl_convert_sched.
// Stats ports exist only when HSL_SCHED_STATS_EN is defined.
interface hsl_convert_sched_if;
  logic        iValidA;
  logic [29:0] iHslA;
  logic        oReadyA;
  logic        oValidA;
  logic [29:0] oRgbA;
  logic        iReadyA;
  logic        iValidB;
  logic [29:0] iHslB;
  logic        oReadyB;
  logic        oValidB;
  logic [29:0] oRgbB;
  logic        iReadyB;
  logic [9:0]  oConvHue;
  logic [9:0]  oConvSat;
  logic [9:0]  oConvLight;
  logic [9:0]  iConvRed;
  logic [9:0]  iConvGreen;
  logic [9:0]  iConvBlue;
  logic        oBusy;
`ifdef HSL_SCHED_STATS_EN
  logic        iStatsClear;
  logic [15:0] oDoneCountA;
  logic [15:0] oDoneCountB;
  logic [15:0] oStallCount;
`endif

  modport master (
    output iValidA, iHslA, iReadyA, iValidB, iHslB, iReadyB,
    output iConvRed, iConvGreen, iConvBlue,
`ifdef HSL_SCHED_STATS_EN
    output iStatsClear,
    input  oDoneCountA, oDoneCountB, oStallCount,
`endif
    input  oReadyA, oValidA, oRgbA, oReadyB, oValidB, oRgbB,
    input  oConvHue, oConvSat, oConvLight, oBusy
  );

  modport slave (
    input  iValidA, iHslA, iReadyA, iValidB, iHslB, iReadyB,
    input  iConvRed, iConvGreen, iConvBlue,
`ifdef HSL_SCHED_STATS_EN
    input  iStatsClear,
    output oDoneCountA, oDoneCountB, oStallCount,
`endif
    output oReadyA, oValidA, oRgbA, oReadyB, oValidB, oRgbB,
    output oConvHue, oConvSat, oConvLight, oBusy
  );
endinterface

// File: rtl/hsl_convert_sched.sv
// Round-robin sharing of one HSL->RGB converter between requesters A and B,
// with tagged write-back into credit-protected FIFOs. Optional: HSL_SCHED_STATS_EN.
module hsl_convert_sched #(
  parameter int unsigned CONV_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic clock,
  input logic reset,
  hsl_convert_sched_if.slave bus
);
  localparam int unsigned PIPE = 1 + CONV_LATENCY;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned OW   = AW + 1;

  typedef enum logic {PREF_A, PREF_B} rr_t;
  rr_t rr_q, rr_d;

  logic [1:0]    req, dn_ready, eligible, grant, wr_en, pop, empty;
  logic [29:0]   hsl      [2];
  logic [29:0]   head     [2];
  logic [AW-1:0] wr_ptr   [2];
  logic [AW-1:0] rd_ptr   [2];
  logic [OW-1:0] occ      [2];
  logic [29:0]   mem      [2][FIFO_DEPTH];
  int unsigned   inflight [2];
  logic          tag_v    [PIPE];
  logic          tag_id   [PIPE];
  logic          pipe_busy;
  logic [29:0]   conv_q;
  logic [29:0]   wr_data;

  assign req      = {bus.iValidB, bus.iValidA};
  assign dn_ready = {bus.iReadyB, bus.iReadyA};
  assign hsl[0]   = bus.iHslA;
  assign hsl[1]   = bus.iHslB;
  assign wr_data  = {bus.iConvRed, bus.iConvGreen, bus.iConvBlue};

  always_comb begin
    inflight[0] = 0;
    inflight[1] = 0;
    pipe_busy   = 1'b0;
    for (int unsigned k = 0; k < PIPE; k++) begin
      pipe_busy = pipe_busy | tag_v[k];
      if (tag_v[k] && tag_id[k])  inflight[1] = inflight[1] + 1;
      if (tag_v[k] && !tag_id[k]) inflight[0] = inflight[0] + 1;
    end
  end

  // Credit is occupancy plus tags still in the pipe; a same-cycle pop is not credited.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      eligible[i] = req[i] && ((32'(occ[i]) + inflight[i]) < FIFO_DEPTH);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_q <= PREF_A;
    else       rr_q <= rr_d;
  end

  always_comb begin
    rr_d = rr_q;
    if (grant[0])      rr_d = PREF_B;
    else if (grant[1]) rr_d = PREF_A;
  end

  always_comb begin
    grant = '0;
    if (!reset) begin
      if (&eligible) grant = (rr_q == PREF_A) ? 2'b01 : 2'b10;
      else           grant = eligible;
    end
  end

  assign bus.oReadyA = grant[0];
  assign bus.oReadyB = grant[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       conv_q <= '0;
    else if (|grant) conv_q <= grant[1] ? hsl[1] : hsl[0];
  end

  assign bus.oConvHue   = conv_q[29:20];
  assign bus.oConvSat   = conv_q[19:10];
  assign bus.oConvLight = conv_q[9:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < PIPE; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= 1'b0;
      end
    end else begin
      tag_v[0]  <= |grant;
      tag_id[0] <= grant[1];
      for (int unsigned k = 1; k < PIPE; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      wr_en[i] = tag_v[PIPE-1] && (tag_id[PIPE-1] == 1'(i));
      empty[i] = (occ[i] == '0);
      pop[i]   = !empty[i] && dn_ready[i];
      head[i]  = empty[i] ? '0 : mem[i][rd_ptr[i]];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        occ[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (wr_en[i] && !pop[i])      occ[i] <= occ[i] + 1'b1;
        else if (pop[i] && !wr_en[i]) occ[i] <= occ[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (wr_en[i]) mem[i][wr_ptr[i]] <= wr_data;
    end
  end

  assign bus.oValidA = !empty[0];
  assign bus.oValidB = !empty[1];
  assign bus.oRgbA   = head[0];
  assign bus.oRgbB   = head[1];
  assign bus.oBusy   = pipe_busy || !(&empty);

`ifdef HSL_SCHED_STATS_EN
  logic [15:0] done_a, done_b, stalls;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_a <= '0;
      done_b <= '0;
      stalls <= '0;
    end else if (bus.iStatsClear) begin
      done_a <= '0;
      done_b <= '0;
      stalls <= '0;
    end else begin
      if (pop[0]) done_a <= done_a + 16'd1;
      if (pop[1]) done_b <= done_b + 16'd1;
      if (|(req & ~grant)) stalls <= stalls + 16'd1;
    end
  end

  assign bus.oDoneCountA = done_a;
  assign bus.oDoneCountB = done_b;
  assign bus.oStallCount = stalls;
`endif
endmodule

// File: tb/tb_hsl_convert_sched.sv
// Scoreboard bench for hsl_convert_sched with a credit/round-robin reference model.
module tb_hsl_convert_sched;
  localparam int unsigned DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  hsl_convert_sched_if bus ();

  hsl_convert_sched #(.CONV_LATENCY(1), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [29:0] conv_f(input logic [29:0] hsl);
    logic [9:0] h, s, l;
    h = hsl[29:20]; s = hsl[19:10]; l = hsl[9:0];
    return {10'(l + h), 10'(l ^ s), 10'(l - s)};
  endfunction

  // External converter: one registered stage.
  logic [29:0] conv_q;
  always @(posedge clock) conv_q <= conv_f({bus.oConvHue, bus.oConvSat, bus.oConvLight});
  assign {bus.iConvRed, bus.iConvGreen, bus.iConvBlue} = conv_q;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [29:0] qa[$];
  logic [29:0] qb[$];
  int unsigned out_a = 0, out_b = 0;
  int unsigned acc_a = 0, acc_b = 0, popped_a = 0, popped_b = 0;
  bit last_b = 1'b1;
  int grant_log[$];

  // Model: a requester is eligible while accepted-minus-popped is below DEPTH.
  always @(negedge clock) begin
    logic ea, eb, ga, gb;
    if (reset) begin
      qa.delete(); qb.delete(); grant_log.delete();
      out_a = 0; out_b = 0; acc_a = 0; acc_b = 0; popped_a = 0; popped_b = 0;
      last_b = 1'b1;
    end else begin
      ea = bus.iValidA && (out_a < DEPTH);
      eb = bus.iValidB && (out_b < DEPTH);
      if (ea && eb) begin ga = last_b; gb = !last_b; end
      else begin ga = ea; gb = eb; end
      check("grant", 32'({bus.oReadyB, bus.oReadyA}), 32'({gb, ga}));
      check("busy", 32'(bus.oBusy), 32'((out_a + out_b) != 0));
      check("spuriousA", 32'(bus.oValidA && qa.size() == 0), 32'(0));
      check("spuriousB", 32'(bus.oValidB && qb.size() == 0), 32'(0));
      if (bus.oValidA && bus.iReadyA && qa.size() != 0) begin
        check("rgbA", 32'(bus.oRgbA), 32'(qa.pop_front()));
        out_a--; popped_a++;
      end
      if (bus.oValidB && bus.iReadyB && qb.size() != 0) begin
        check("rgbB", 32'(bus.oRgbB), 32'(qb.pop_front()));
        out_b--; popped_b++;
      end
      if (ga) begin
        qa.push_back(conv_f(bus.iHslA)); out_a++; acc_a++; last_b = 1'b0; grant_log.push_back(0);
      end
      if (gb) begin
        qb.push_back(conv_f(bus.iHslB)); out_b++; acc_b++; last_b = 1'b1; grant_log.push_back(1);
      end
    end
  end

  task automatic cyc(input logic va, input logic [29:0] ha, input logic ra,
                     input logic vb, input logic [29:0] hb, input logic rb);
    bus.iValidA = va; bus.iHslA = ha; bus.iReadyA = ra;
    bus.iValidB = vb; bus.iHslB = hb; bus.iReadyB = rb;
    @(posedge clock); #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctl"}, 32'({bus.oReadyA, bus.oReadyB, bus.oValidA, bus.oValidB, bus.oBusy}), 32'(0));
    check({tag, "_rgb"}, 32'(|{bus.oRgbA, bus.oRgbB}), 32'(0));
    check({tag, "_conv"}, 32'({bus.oConvHue, bus.oConvSat, bus.oConvLight}), 32'(0));
  endtask

  task automatic do_reset();
    bus.iValidA = 1'b0; bus.iValidB = 1'b0; bus.iReadyA = 1'b0; bus.iReadyB = 1'b0;
    reset = 1'b1;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    int lat;
    bus.iHslA = '0; bus.iHslB = '0;
`ifdef HSL_SCHED_STATS_EN
    bus.iStatsClear = 1'b0;
`endif
    @(posedge clock); #1;
    do_reset();

    // Single A pixel, grey input.
    cyc(1'b1, {10'd0, 10'd0, 10'h200}, 1'b1, 1'b0, '0, 1'b1);
    bus.iValidA = 1'b0;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!bus.oValidA && lat < 20);
    check("single_latency", 32'(lat), 32'(3));
    check("single_rgb", 32'(bus.oRgbA), 32'({10'h200, 10'h200, 10'h200}));
    @(negedge clock);
    check("single_busy_low", 32'(bus.oBusy), 32'(0));
    @(posedge clock); #1;

    // Both requesting for 8 cycles: strict alternation starting with A.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 30'($urandom), 1'b1, 1'b1, 30'($urandom), 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    check("alt_acc_a", 32'(acc_a), 32'(4));
    check("alt_acc_b", 32'(acc_b), 32'(4));
    check("alt_log_len", 32'(grant_log.size()), 32'(8));
    for (int i = 0; i < 8 && i < grant_log.size(); i++) check("alt_order", 32'(grant_log[i]), 32'(i % 2));
    check("alt_drained", 32'(popped_a + popped_b), 32'(8));
`ifdef HSL_SCHED_STATS_EN
    check("stats_done_a", 32'(bus.oDoneCountA), 32'(4));
    check("stats_done_b", 32'(bus.oDoneCountB), 32'(4));
    check("stats_stall", 32'(bus.oStallCount), 32'(8));
    bus.iStatsClear = 1'b1;
    @(posedge clock); #1;
    bus.iStatsClear = 1'b0;
    check("stats_clear", 32'({bus.oDoneCountA, bus.oDoneCountB} | 32'(bus.oStallCount)), 32'(0));
`endif

    // Backpressure on A: credit stops issue at DEPTH, then resumes per pop.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 30'($urandom), 1'b0, 1'b0, '0, 1'b1);
    check("bp_acc_a", 32'(acc_a), 32'(DEPTH));
    check("bp_ready_low", 32'(bus.oReadyA), 32'(0));
    for (int i = 0; i < 20; i++) cyc(1'b1, 30'($urandom), 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    check("bp_no_loss", 32'(popped_a), 32'(acc_a));
    check("bp_q_empty", 32'(qa.size()), 32'(0));

    // Random traffic and backpressure on both sides.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 30'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 3) != 0, 30'($urandom), $urandom_range(0, 2) != 0);
    for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    check("rand_q_empty", 32'(qa.size() + qb.size()), 32'(0));
    check("rand_no_loss", 32'(popped_a + popped_b), 32'(acc_a + acc_b));

    // Reset in the middle of traffic.
    for (int i = 0; i < 6; i++) cyc(1'b1, 30'($urandom), 1'b0, 1'b1, 30'($urandom), 1'b0);
    check("midrst_pre_valid", 32'({bus.oValidA, bus.oValidB}), 32'(2'b11));
    #2 reset = 1'b1;
    #1;
    check_zero_outputs("midrst");
    bus.iValidA = 1'b0; bus.iValidB = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    bus.iReadyA = 1'b1; bus.iReadyB = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("midrst_no_stale", 32'({bus.oValidA, bus.oValidB}), 32'(0));
    end
    @(posedge clock); #1;
    for (int i = 0; i < 30; i++)
      cyc($urandom_range(0, 1) != 0, 30'($urandom), 1'b1, $urandom_range(0, 1) != 0, 30'($urandom), 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    check("post_rst_drained", 32'(qa.size() + qb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/hsl_convert_sched.md
Name: hsl_convert_sched

Overview:
- Shares one HSL-to-RGB converter instance between two pixel requesters, A and B. In the realtime pipeline these are the live video path and the overlay/recolour path.
- Arbitrates round-robin and issues at most one pixel per clock.
- Tags each pixel through the converter's fixed latency.
- Steers each result into a per-requester output FIFO. Credit-based issue guarantees the FIFOs never overflow.

Parameters:
- CONV_LATENCY, 1: clocks from converter input change to the registered RGB result.
- FIFO_DEPTH, 4: entries per output FIFO. Power of two, range 2..16.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- iValidA  in  1  requester A pixel valid.
- iHslA  in  30  {H[29:20], S[19:10], L[9:0]}.
- oReadyA  out  1  A pixel accepted this cycle.
- oValidA  out  1  A RGB result available.
- oRgbA  out  30  {R[29:20], G[19:10], B[9:0]}.
- iReadyA  in  1  A downstream accepts result.
- iValidB, iHslB, oReadyB, oValidB, oRgbB, iReadyB: same as A, for requester B.
- oConvHue, oConvSat, oConvLight  out  10 each  registered converter inputs.
- iConvRed, iConvGreen, iConvBlue  in  10 each  converter outputs.
- oBusy  out  1  any pixel in flight or any FIFO non-empty.

Behaviour:
- Reset values: all outputs 0; FIFOs empty; tag pipe cleared; RR pointer favours A.
- Reset asserted mid-operation discards all in-flight tags and FIFO contents. Converter outputs are ignored until new tags arrive.
- Eligibility: X is eligible when iValidX=1 and occX + inflightX < FIFO_DEPTH.
  - occX is FIFO occupancy.
  - inflightX is the count of X tags in the pipe.
  - A same-cycle pop does not free credit until the next cycle (conservative).
- Arbitration:
  - Only one eligible: it is granted.
  - Both eligible: grant goes to the requester not granted most recently.
  - The pointer updates only on a grant.
- oReadyX is combinational and equals grantX. A transfer happens when iValidX and oReadyX are both high.
- Issue: on a grant, the selected H/S/L are registered into oConv*. On an idle cycle oConv* hold their previous values.
- Tag pipe: shift register of depth 1+CONV_LATENCY. Each entry holds {valid, id}; the issue stage pushes {grant_any, grantB}.
- Write-back: when the tail entry is valid, {iConvRed, iConvGreen, iConvBlue} are written to FIFO[id] in that cycle. Accept-to-FIFO-write latency is 1+CONV_LATENCY clocks; oValidX rises the following cycle.
- FIFO behaviour:
  - Show-ahead: oValidX = !empty, and oRgbX is the head entry.
  - Pop when oValidX & iReadyX.
  - Simultaneous write and pop is legal at any occupancy, including full, and leaves occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering: results per requester are returned in acceptance order. Ordering between A and B follows the grant order.
- Throughput: one pixel per clock aggregate. A single requester gets 1 pixel/clk when the other is idle and its own downstream is always ready.
- Overflow is impossible by construction. A write to a full FIFO is a design error; the bench asserts it never happens.

Optional Feature:
- Macro HSL_SCHED_STATS_EN.
- Defined: adds ports oDoneCountA, oDoneCountB (16-bit, count results popped per requester) and oStallCount (16-bit, counts cycles with iValidX=1 and oReadyX=0 for any X). All counters wrap, reset to 0, and are synchronously cleared by input iStatsClear.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single A pixel, H=0, S=0, L=10'h200, B idle, iReadyA=1 -> oReadyA same cycle; oValidA high 3 clocks later (CONV_LATENCY=1); oRgbA={10'h200,10'h200,10'h200}; oBusy falls the cycle after the pop.
- A and B valid every cycle for 8 cycles, both iReady=1 -> grants alternate A,B,A,B..., starting with A after reset; 4 results each, per-requester order preserved.
- iReadyA=0, A valid continuously, B idle -> exactly 4 A pixels accepted, then oReadyA=0. Raise iReadyA -> acceptances resume one per pop with no loss or duplication.
- A FIFO full and being popped while a new A tag writes back -> occupancy stays 4; data order intact; no overflow assertion.
- Assert reset while 2 pixels are in flight and both FIFOs are non-empty -> all outputs 0 immediately; after release, no stale results appear.
- With HSL_SCHED_STATS_EN: run the 8-cycle alternating test -> oDoneCountA=4, oDoneCountB=4, oStallCount=8. Pulse iStatsClear -> all counters 0.
